// File: rtl/pos_pkg.sv
// Shared constants for the per-wheel encoder position counters.
package pos_pkg;

  localparam int POS_W     = 16;
  localparam int CLR_TRIP  = 0;
  localparam int CLR_ACCUM = 1;

endpackage

// File: rtl/pos_edge_detect.sv
// Sensor rising-edge detector producing a one-cycle strobe.
// Optional 2-flop input synchronizer is enabled by defining POS_SENSOR_SYNC_EN.
module pos_edge_detect
  import pos_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sensor,
  output logic o_edge
);

  logic w_sensor;
  logic r_sensor_d;

`ifdef POS_SENSOR_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= sensor;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sensor = r_sync2;
`else
  assign w_sensor = sensor;
`endif

  // NOTE: the delayed sample resets high so a sensor already asserted at
  // reset release is treated as old level, not as a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) r_sensor_d <= 1'b1;
    else     r_sensor_d <= w_sensor;
  end

  assign o_edge = w_sensor & ~r_sensor_d;

endmodule

// File: rtl/pos_counter.sv
// Per-wheel encoder pulse counter: trip counter pos1 and rebasable accumulator pos2.
// Define POS_SENSOR_SYNC_EN to insert a 2-flop synchronizer ahead of the edge detector.
module pos_counter
  import pos_pkg::*;
#(
  parameter int W = POS_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sensor,
  input  logic [1:0]   clear,
  input  logic         subtract,
  input  logic [W-1:0] distance,
  output logic [W-1:0] pos1,
  output logic [W-1:0] pos2
);

  logic         w_edge;
  logic [W-1:0] w_inc;
  logic [W-1:0] w_dec;
  logic [W-1:0] r_pos1;
  logic [W-1:0] r_pos2;

  pos_edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .sensor (sensor),
    .o_edge (w_edge)
  );

  assign w_inc = {{(W-1){1'b0}}, w_edge};
  assign w_dec = subtract ? distance : '0;

  // NOTE: state registers use non-blocking assignments so every counter
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos1 <= '0;
      r_pos2 <= '0;
    end else begin
      if (clear[CLR_TRIP]) r_pos1 <= '0;
      else                 r_pos1 <= r_pos1 + w_inc;

      // Rebase and a coincident edge are both applied so no count is lost.
      if (clear[CLR_ACCUM]) r_pos2 <= '0;
      else                  r_pos2 <= r_pos2 - w_dec + w_inc;
    end
  end

  assign pos1 = r_pos1;
  assign pos2 = r_pos2;

endmodule

// File: tb/tb_pos_counter.sv
// Scoreboard bench for pos_counter: directed plan plus randomized traffic
// against a count-the-rising-edges reference model.
module tb_pos_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sensor = 1'b0;
  logic [1:0]  clear = 2'b00;
  logic        subtract = 1'b0;
  logic [15:0] distance = '0;
  logic [15:0] pos1, pos2;

  logic        sensor8 = 1'b0;
  logic [7:0]  pos1_8, pos2_8;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  exp8_q[$];

  // reference model state
  logic [15:0] m_p1, m_p2;
  bit          m_prev;
  logic [7:0]  m8_p1;
  bit          m8_prev;

  always #5 clk = ~clk;

  pos_counter #(.W(16)) dut (
    .clk(clk), .rst(rst), .sensor(sensor), .clear(clear),
    .subtract(subtract), .distance(distance), .pos1(pos1), .pos2(pos2)
  );

  pos_counter #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .sensor(sensor8), .clear(2'b00),
    .subtract(1'b0), .distance(8'h00), .pos1(pos1_8), .pos2(pos2_8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, advance the model, optionally queue expectations.
  task automatic cyc(input bit r, input bit s, input logic [1:0] c, input bit sub,
                     input logic [15:0] d, input bit chk, input bit s8 = 1'b0,
                     input bit chk8 = 1'b0);
    bit e, e8;
    rst = r; sensor = s; clear = c; subtract = sub; distance = d; sensor8 = s8;
    if (r) begin
      m_p1 = 0; m_p2 = 0; m_prev = 1; m8_p1 = 0; m8_prev = 1;
    end else begin
      e  = s && !m_prev;
      e8 = s8 && !m8_prev;
      m_prev  = s;
      m8_prev = s8;
      m_p1  = c[0] ? 16'd0 : m_p1 + 16'(e);
      m_p2  = c[1] ? 16'd0 : m_p2 - (sub ? d : 16'd0) + 16'(e);
      m8_p1 = m8_p1 + 8'(e8);
    end
    @(posedge clk);
    #1;
    if (chk)  exp_q.push_back({m_p1, m_p2});
    if (chk8) exp8_q.push_back(m8_p1);
  endtask

  task automatic idle(input bit chk = 1'b0);
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 16'd0, chk);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b1, 2'b00, 1'b0, 16'd0, 1'b0);
      cyc(1'b0, 1'b0, 2'b00, 1'b0, 16'd0, 1'b0);
    end
  endtask

  task automatic do_reset(input bit s);
    cyc(1'b1, s, 2'b00, 1'b0, 16'd0, 1'b0);
    cyc(1'b1, s, 2'b00, 1'b0, 16'd0, 1'b1);
  endtask

  // Monitor: outputs are registered and always valid; compare whenever an expectation waits.
  always @(negedge clk) begin
    logic [31:0] e;
    logic [7:0]  e8;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pos1", 32'(pos1), 32'(e[31:16]));
      check("pos2", 32'(pos2), 32'(e[15:0]));
    end
    if (exp8_q.size() > 0) begin
      e8 = exp8_q.pop_front();
      check("pos1_w8", 32'(pos1_8), 32'(e8));
    end
  end

  initial begin
    m_p1 = 0; m_p2 = 0; m_prev = 1; m8_p1 = 0; m8_prev = 1;

    // reset state, then three pulses
    do_reset(1'b0);
    pulses(3);
    idle(1'b1);

    // sensor high through reset is not counted; held-high pulse counts once
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 2'b00, 1'b0, 16'd0, 1'b1);
    idle(1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 2'b00, 1'b0, 16'd0, 1'b1);

    // 16 pulses, then clear trip, then clear accumulator
    do_reset(1'b0);
    pulses(16);
    idle(1'b1);
    cyc(1'b0, 1'b0, 2'b01, 1'b0, 16'd0, 1'b1);
    cyc(1'b0, 1'b0, 2'b10, 1'b0, 16'd0, 1'b1);

    // rebase wrap to 0x8010, then rebase with and without a coincident edge
    cyc(1'b0, 1'b0, 2'b00, 1'b1, 16'h7FF0, 1'b1);
    cyc(1'b0, 1'b1, 2'b00, 1'b1, 16'h8010, 1'b1);
    cyc(1'b0, 1'b0, 2'b00, 1'b1, 16'h7FF1, 1'b1);
    cyc(1'b0, 1'b0, 2'b00, 1'b1, 16'h8010, 1'b1);

    // pulse with clear both, then pulse with clear trip only
    pulses(5);
    cyc(1'b0, 1'b1, 2'b11, 1'b0, 16'd0, 1'b1);
    idle(1'b1);
    pulses(2);
    cyc(1'b0, 1'b1, 2'b01, 1'b0, 16'd0, 1'b1);
    idle(1'b1);

    // subtract leaves pos1 alone
    cyc(1'b0, 1'b0, 2'b00, 1'b1, 16'd1, 1'b1);

    // reset overrides a coincident edge mid-count
    pulses(4);
    cyc(1'b1, 1'b1, 2'b00, 1'b0, 16'd0, 1'b1);
    cyc(1'b0, 1'b1, 2'b00, 1'b0, 16'd0, 1'b1);

    // randomized traffic; rebase amount kept within the current accumulator
    for (int i = 0; i < 3000; i++) begin
      bit          s, sub;
      logic [1:0]  c;
      logic [15:0] d;
      s   = 1'($urandom_range(1, 0));
      c   = ($urandom_range(15, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      sub = ($urandom_range(7, 0) == 0);
      d   = 16'($urandom_range(32'(m_p2), 0));
      cyc(1'b0, s, c, sub, d, 1'b1);
    end

    // trip counter wrap on an 8-bit instance
    for (int i = 0; i < 255; i++) begin
      cyc(1'b0, 1'b0, 2'b00, 1'b0, 16'd0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 2'b00, 1'b0, 16'd0, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size() + exp8_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
